// File: rtl/cn_sched_pkg.sv
// cn_sched_pkg: shared decoder constants, ecomp width and scheduler state encoding
package cn_sched_pkg;
  localparam int CN_W     = 6;
  localparam int CN_WC    = 18;
  localparam int CN_NROWS = 9;
  localparam int CN_LAT   = 4;
  localparam int CN_RDLAT = 1;
  localparam int CN_ITW   = 5;
  localparam int CN_ECW   = 2 * (CN_W - 1) + 5 + CN_WC;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_FIN   = 3'd4;
  function automatic int ecomp_w(input int w, input int wc);
    return 2 * (w - 1) + 5 + wc;
  endfunction
endpackage

// File: rtl/cn_sched_dly.sv
// cn_sched_dly: fixed-depth valid/address delay line with synchronous flush of the valid bits
module cn_sched_dly #(
  parameter int D  = 5,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_flush,
  input  logic          i_vld,
  input  logic [AW-1:0] i_addr,
  output logic          o_vld,
  output logic [AW-1:0] o_addr,
  output logic          o_pend
);
  logic [D-1:0]  r_vld;
  logic [AW-1:0] r_addr [D];
  // Shift every cycle; a flush kills all in-flight valid bits including the one entering
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld <= '0;
      for (int i = 0; i < D; i++) r_addr[i] <= '0;
    end else begin
      for (int i = D - 1; i > 0; i--) begin
        r_vld[i]  <= r_vld[i-1] & ~i_flush;
        r_addr[i] <= r_addr[i-1];
      end
      r_vld[0]  <= i_vld & ~i_flush;
      r_addr[0] <= i_addr;
    end
  end
  assign o_vld  = r_vld[D-1];
  assign o_addr = r_addr[D-1];
  // Anything still in flight behind the output stage
  assign o_pend = |(r_vld & ~(D'(1) << (D - 1)));
endmodule

// File: rtl/cn_sched.sv
// cn_sched: check-node row scheduler issuing row reads and timing ecomp writes per iteration
module cn_sched
  import cn_sched_pkg::*;
#(
  parameter int W     = CN_W,
  parameter int WC    = CN_WC,
  parameter int NROWS = CN_NROWS,
  parameter int LAT   = CN_LAT,
  parameter int RDLAT = CN_RDLAT,
  parameter int ITW   = CN_ITW,
  localparam int AW   = (NROWS > 1) ? $clog2(NROWS) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [ITW-1:0] max_iter,
  input  logic           issue_hold,
  input  logic           abort,
  input  logic           parity_ok,
  output logic           rd_en,
  output logic [AW-1:0]  rd_addr,
  output logic           wr_en,
  output logic [AW-1:0]  wr_addr,
  output logic           busy,
  output logic           done,
  output logic           success,
  output logic [ITW-1:0] iter_cnt
);
  if (W < 2 || WC < 2 || ecomp_w(W, WC) < 1 || NROWS < 1 || LAT < 1 || RDLAT < 0 || ITW < 1) begin : g_bad_cfg
    $error("cn_sched: illegal parameter set");
  end
  logic [2:0]     r_state;
  logic [ITW-1:0] r_max;
  logic [AW-1:0]  r_rd_addr;
  logic           w_last;
  logic           w_pend;
  logic           w_flush;
  assign busy    = r_state != S_IDLE;
  assign done    = r_state == S_FIN;
  assign rd_en   = (r_state == S_ISSUE) && !issue_hold;
  assign rd_addr = r_rd_addr;
  assign w_last  = r_rd_addr == AW'(NROWS - 1);
  assign w_flush = abort && busy;
  // Scheduler FSM: abort overrides everything; success/iter_cnt persist until the next accepted start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_rd_addr <= '0;
      r_max     <= '0;
      success   <= 1'b0;
      iter_cnt  <= '0;
    end else if (w_flush) begin
      r_state <= S_FIN;
      success <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_state   <= S_ISSUE;
          r_rd_addr <= '0;
          iter_cnt  <= '0;
          success   <= 1'b0;
          r_max     <= (max_iter == '0) ? ITW'(1) : max_iter;
        end
        S_ISSUE: if (rd_en) begin
          if (w_last) r_state <= S_DRAIN;
          else r_rd_addr <= r_rd_addr + 1'b1;
        end
        S_DRAIN: if (!w_pend) begin
          r_state  <= S_CHECK;
          iter_cnt <= (&iter_cnt) ? iter_cnt : iter_cnt + 1'b1;
        end
        S_CHECK: begin
          if (parity_ok || iter_cnt == r_max) begin
            r_state <= S_FIN;
            success <= parity_ok;
          end else begin
            r_state   <= S_ISSUE;
            r_rd_addr <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
  cn_sched_dly #(.D(RDLAT + LAT), .AW(AW)) u_dly (
    .clk    (clk),
    .rst    (rst),
    .i_flush(w_flush),
    .i_vld  (rd_en),
    .i_addr (r_rd_addr),
    .o_vld  (wr_en),
    .o_addr (wr_addr),
    .o_pend (w_pend)
  );
endmodule

// File: tb/tb_cn_sched.sv
// tb_cn_sched: table-driven scheduler runs plus reset and abort corner sequences
module tb_cn_sched;
  localparam int NROWS = 9;
  localparam int D     = 5;
  localparam int ITW   = 5;
  localparam int AW    = 4;
  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic           issue_hold = 1'b0;
  logic           abort = 1'b0;
  logic           parity_ok = 1'b0;
  logic [ITW-1:0] max_iter = '0;
  logic           rd_en, wr_en, busy, done, success;
  logic [AW-1:0]  rd_addr, wr_addr;
  logic [ITW-1:0] iter_cnt;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  cn_sched dut (
    .clk(clk), .rst(rst), .start(start), .max_iter(max_iter), .issue_hold(issue_hold),
    .abort(abort), .parity_ok(parity_ok), .rd_en(rd_en), .rd_addr(rd_addr), .wr_en(wr_en),
    .wr_addr(wr_addr), .busy(busy), .done(done), .success(success), .iter_cnt(iter_cnt)
  );
  typedef struct {
    int id;
    int mi;
    int par_iter;
    int hold_row;
    int abort_row;
    int start_again;
    int exp_done;
    int exp_wr;
    int exp_succ;
    int exp_iter;
  } vec_t;
  vec_t tbl[6];
  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic chk_all_zero(input string nm);
    chk({nm, "_rd_en"}, rd_en, 0);
    chk({nm, "_wr_en"}, wr_en, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_success"}, success, 0);
    chk({nm, "_rd_addr"}, rd_addr, 0);
    chk({nm, "_wr_addr"}, wr_addr, 0);
    chk({nm, "_iter_cnt"}, iter_cnt, 0);
  endtask
  task automatic run_case(input vec_t v);
    int wr_cnt = 0;
    int exp_row = 0;
    int hold_left = 0;
    bit hold_used = 0;
    bit abort_next = 0;
    bit done_seen = 0;
    int q_cyc[$];
    int q_row[$];
    for (int cyc = 0; cyc < 600 && !done_seen; cyc++) begin
      @(negedge clk);
      start      = (cyc == 0) || (cyc == v.start_again);
      max_iter   = (cyc == 0) ? ITW'(v.mi) : 5'd7;
      issue_hold = hold_left > 0;
      if (hold_left > 0) hold_left--;
      abort      = abort_next;
      abort_next = 0;
      parity_ok  = v.par_iter > 0 && wr_cnt >= v.par_iter * NROWS;
      #1;
      if (issue_hold) chk($sformatf("c%0d_hold_rd_en", v.id), rd_en, 0);
      if (rd_en) begin
        chk($sformatf("c%0d_rd_addr", v.id), rd_addr, exp_row);
        if (!abort) begin
          q_cyc.push_back(cyc);
          q_row.push_back(exp_row);
        end
        if (exp_row == v.hold_row && !hold_used) begin
          hold_left = 2;
          hold_used = 1;
        end
        if (exp_row == v.abort_row && !abort) abort_next = 1;
        exp_row = (exp_row == NROWS - 1) ? 0 : exp_row + 1;
      end
      if (wr_en) begin
        if (q_row.size() == 0) chk($sformatf("c%0d_spurious_wr_cyc%0d", v.id, cyc), 1, 0);
        else begin
          chk($sformatf("c%0d_wr_addr", v.id), wr_addr, q_row.pop_front());
          chk($sformatf("c%0d_wr_lat", v.id), cyc - q_cyc.pop_front(), D);
        end
        wr_cnt++;
      end
      if (abort) begin
        q_cyc.delete();
        q_row.delete();
      end
      if (done) begin
        done_seen = 1;
        chk($sformatf("c%0d_done_cyc", v.id), cyc, v.exp_done);
        chk($sformatf("c%0d_success", v.id), success, v.exp_succ);
        chk($sformatf("c%0d_iter_cnt", v.id), iter_cnt, v.exp_iter);
        chk($sformatf("c%0d_writes", v.id), wr_cnt, v.exp_wr);
      end
    end
    if (!done_seen) chk($sformatf("c%0d_done_timeout", v.id), 0, 1);
    @(negedge clk);
    start = 0; issue_hold = 0; abort = 0; parity_ok = 0;
    #1;
    chk($sformatf("c%0d_done_pulse", v.id), done, 0);
    chk($sformatf("c%0d_idle_busy", v.id), busy, 0);
    chk($sformatf("c%0d_idle_wr_en", v.id), wr_en, 0);
    chk($sformatf("c%0d_success_hold", v.id), success, v.exp_succ);
    chk($sformatf("c%0d_iter_hold", v.id), iter_cnt, v.exp_iter);
    chk($sformatf("c%0d_pending_rows", v.id), q_row.size(), 0);
  endtask
  initial begin
    tbl[0] = '{0, 5, 1, -1, -1, -1, 16, 9, 1, 1};
    tbl[1] = '{1, 3, 0, -1, -1, -1, 46, 27, 0, 3};
    tbl[2] = '{2, 2, 1, 3, -1, -1, 18, 9, 1, 1};
    tbl[3] = '{3, 3, 0, -1, 6, -1, 9, 3, 0, 0};
    tbl[4] = '{4, 0, 0, -1, -1, 3, 16, 9, 0, 1};
    tbl[5] = '{5, 2, 2, -1, -1, -1, 31, 18, 1, 2};
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 6; i++) run_case(tbl[i]);
    @(negedge clk);
    start = 1; max_iter = 5'd1; parity_ok = 1;
    @(negedge clk);
    start = 0;
    repeat (11) @(negedge clk);
    #1;
    chk("drain_wr_en_before_rst", wr_en, 1);
    #1 rst = 1;
    #1;
    chk_all_zero("async_rst");
    @(posedge clk);
    #1;
    chk_all_zero("rst_held");
    @(negedge clk);
    rst = 0; parity_ok = 0;
    run_case(tbl[0]);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
